hbm_rd_scheduler: RTL

Issues AXI3 read-address bursts to one HBM pseudo-channel on behalf of the SGD engine. It fetches the sample matrix A and the label vector B from two base addresses, interleaving B bursts among A bursts. Each burst carries `MEM_RD_A_TAG` or `MEM_RD_B_TAG` on ARID so the read-response dispatcher can route the returning data. The scheduler tracks outstanding bursts by snooping RLAST and throttles issue on A-buffer backpressure.

---
 rtl/hbm_rd_scheduler_pkg.sv | 34 +++
 rtl/hbm_rd_scheduler_if.sv | 28 ++
 rtl/hbm_rd_scheduler_outstanding_cnt.sv | 42 ++++
 rtl/hbm_rd_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hbm_rd_scheduler_pkg.sv
// Shared definitions for the HBM read-address scheduler: ARID routing tags,
// beat geometry and the scheduler FSM state type.
package hbm_rd_scheduler_pkg;

  // ARID tags decoded by the read-response dispatcher
  localparam logic [5:0] MEM_RD_A_TAG = 6'd1;
  localparam logic [5:0] MEM_RD_B_TAG = 6'd2;

  // One beat is 32 bytes (ARSIZE = 3'b101)
  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEAT_SHIFT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic {
    SEL_A,
    SEL_B
  } sel_e;

  // Beats in the next burst: the remaining beat count clipped to the burst limit
  function automatic logic [4:0] clip_beats(input logic [31:0] rem, input int unsigned max_beats);
    if (rem >= 32'(max_beats)) begin
      return 5'(max_beats);
    end
    return rem[4:0];
  endfunction

endpackage

// File: rtl/hbm_rd_scheduler_if.sv
// AXI3 read-address channel plus the snooped read-response handshake.
interface hbm_rd_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned ID_WIDTH   = 6
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;

  // Scheduler side: drives AR, observes AR acceptance and the R handshake
  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    input  ARREADY, RVALID, RREADY, RLAST
  );

  // Memory / response side
  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    output ARREADY, RVALID, RREADY, RLAST
  );
endinterface

// File: rtl/hbm_rd_scheduler_outstanding_cnt.sv
// Saturating up/down counter of in-flight bursts with full/empty flags.
// Simultaneous increment and decrement leave the count unchanged.
module hbm_outstanding_cnt #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: step only on a lone inc/dec, clamped to [0, MAX_COUNT]
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != MAX_Q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == MAX_Q);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/hbm_rd_scheduler.sv
// Issues AXI3 read-address bursts for the A matrix and B label streams,
// inserting one B burst after every A_PER_B A bursts, limiting in-flight
// bursts and holding off A issue while the A buffer is almost full.
module hbm_rd_scheduler
  import hbm_rd_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 33,
  parameter int unsigned ID_WIDTH        = 6,
  parameter int unsigned BURST_BEATS     = 16,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned A_PER_B         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base_addr,
  input  logic [31:0]           a_length,
  input  logic [ADDR_WIDTH-1:0] b_base_addr,
  input  logic [31:0]           b_length,
  input  logic                  a_almost_full,
  hbm_rd_scheduler_if.master    m_axi,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            outstanding,
  output logic [31:0]           issued_a_cnt,
  output logic [31:0]           issued_b_cnt
);
  localparam int unsigned ILV_W = $clog2(A_PER_B + 1);
  localparam logic [ILV_W-1:0] ILV_MAX = ILV_W'(A_PER_B);

  state_e                state_q, state_d;
  sel_e                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic [31:0]           a_rem_q, a_rem_d;
  logic [31:0]           b_rem_q, b_rem_d;
  logic [ILV_W-1:0]      ilv_q, ilv_d;
  logic [31:0]           issued_a_q, issued_a_d;
  logic [31:0]           issued_b_q, issued_b_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [3:0]            arlen_q, arlen_d;

  logic                  ar_hs;
  logic                  r_last_hs;
  logic                  cnt_full;
  logic                  cnt_empty;
  logic                  pick_b;
  logic [4:0]            a_beats;
  logic [4:0]            b_beats;
  logic [4:0]            iss_beats;
  logic [ADDR_WIDTH-1:0] iss_bytes;

  assign ar_hs     = arvalid_q & m_axi.ARREADY;
  assign r_last_hs = m_axi.RVALID & m_axi.RREADY & m_axi.RLAST;
  assign pick_b    = (b_rem_q != '0) && ((ilv_q == ILV_MAX) || (a_rem_q == '0));
  assign a_beats   = clip_beats(a_rem_q, BURST_BEATS);
  assign b_beats   = clip_beats(b_rem_q, BURST_BEATS);
  assign iss_beats = {1'b0, arlen_q} + 5'd1;
  assign iss_bytes = ADDR_WIDTH'(iss_beats) << BEAT_SHIFT;

  hbm_outstanding_cnt #(
    .WIDTH     (4),
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .count_o (outstanding),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // Scheduler next state, stream bookkeeping and AR payload
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_rem_d    = a_rem_q;
    b_rem_d    = b_rem_q;
    ilv_d      = ilv_q;
    issued_a_d = issued_a_q;
    issued_b_d = issued_b_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_addr_d   = a_base_addr;
          b_addr_d   = b_base_addr;
          a_rem_d    = a_length >> BEAT_SHIFT;
          b_rem_d    = b_length >> BEAT_SHIFT;
          ilv_d      = '0;
          issued_a_d = '0;
          issued_b_d = '0;
          state_d    = ST_ARB;
        end
      end
      ST_ARB: begin
        if (a_rem_q == '0 && b_rem_q == '0) begin
          state_d = ST_DRAIN;
        end else if (!cnt_full) begin
          // Not draining and not picking B means A still has beats left
          if (pick_b) begin
            sel_d     = SEL_B;
            araddr_d  = b_addr_q;
            arid_d    = ID_WIDTH'(MEM_RD_B_TAG);
            arlen_d   = 4'(b_beats - 5'd1);
            arvalid_d = 1'b1;
            state_d   = ST_ISSUE;
          end else if (!a_almost_full) begin
            sel_d     = SEL_A;
            araddr_d  = a_addr_q;
            arid_d    = ID_WIDTH'(MEM_RD_A_TAG);
            arlen_d   = 4'(a_beats - 5'd1);
            arvalid_d = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          if (sel_q == SEL_B) begin
            b_rem_d    = b_rem_q - 32'(iss_beats);
            b_addr_d   = b_addr_q + iss_bytes;
            issued_b_d = issued_b_q + 32'd1;
            ilv_d      = '0;
          end else begin
            a_rem_d    = a_rem_q - 32'(iss_beats);
            a_addr_d   = a_addr_q + iss_bytes;
            issued_a_d = issued_a_q + 32'd1;
            // Saturates at A_PER_B; only reachable without B work left
            if (ilv_q != ILV_MAX) begin
              ilv_d = ilv_q + 1'b1;
            end
          end
          state_d = ST_ARB;
        end
      end
      ST_DRAIN: begin
        if (cnt_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_A;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_rem_q    <= '0;
      b_rem_q    <= '0;
      ilv_q      <= '0;
      issued_a_q <= '0;
      issued_b_q <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= '0;
      arlen_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_rem_q    <= a_rem_d;
      b_rem_q    <= b_rem_d;
      ilv_q      <= ilv_d;
      issued_a_q <= issued_a_d;
      issued_b_q <= issued_b_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
    end
  end

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARID    = arid_q;
  assign m_axi.ARLEN   = arlen_q;
  assign m_axi.ARSIZE  = 3'b101;
  assign m_axi.ARBURST = 2'b01;

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign issued_a_cnt = issued_a_q;
  assign issued_b_cnt = issued_b_q;

endmodule
